// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and validity helper.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the counter with load, step up/down and limit flags.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_digit,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);
  assign at_max = digit == BCD_MAX;
  assign at_min = digit == BCD_MIN;
  always_ff @(posedge clk)
    if (reset) digit <= BCD_MIN;
    else if (load) digit <= ld_digit;
    else if (step) digit <= up_dn ? (at_max ? BCD_MIN : digit + 4'd1)
                                  : (at_min ? BCD_MAX : digit - 4'd1);
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-decade up/down BCD counter with load, wrap/saturate and event pulses.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);
  logic [DIGITS-1:0] at_max, at_min, dig_ok;
  logic [DIGITS:0] all_max, all_min;
  logic load_ok, count;
  assign all_max[0] = 1'b1;
  assign all_min[0] = 1'b1;
  assign load_ok = &dig_ok;
  assign tc = en & (up_dn ? all_max[DIGITS] : all_min[DIGITS]);
  // saturating mode suppresses the step entirely so every decade holds at the limit
  assign count = en & ~load & ~(!WRAP && tc);
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign dig_ok[k] = is_bcd(load_val[4*k +: 4]);
    assign all_max[k+1] = all_max[k] & at_max[k];
    assign all_min[k+1] = all_min[k] & at_min[k];
    bcd_digit u_digit (
      .clk(clk),
      .reset(reset),
      .load(load & load_ok),
      .ld_digit(load_val[4*k +: 4]),
      .step(count & (up_dn ? all_max[k] : all_min[k])),
      .up_dn(up_dn),
      .digit(Q[4*k +: 4]),
      .at_max(at_max[k]),
      .at_min(at_min[k])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      ovf <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ovf <= ~load & tc;
      load_err <= load & ~load_ok;
    end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: scoreboard bench driving a wrapping and a saturating 2-digit counter in parallel.
module tb_bcd_counter_n;
  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] q1, q2;
  logic tc1, tc2, ovf1, ovf2, le1, le2;
  int compared = 0, mismatched = 0;
  int m1 = 0, m2 = 0;
  bit o1 = 0, o2 = 0, l1 = 0, l2 = 0;
  typedef struct {
    string name;
    logic [7:0] q1, q2;
    logic o1, o2, l1, l2, t1, t2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .Q(q1), .tc(tc1), .ovf(ovf1), .load_err(le1)
  );
  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .Q(q2), .tc(tc2), .ovf(ovf2), .load_err(le2)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic mstep(inout int m, inout bit o, inout bit l, input bit w,
                       input bit r, input bit ld, input logic [7:0] lv, input bit e, input bit u);
    o = 0;
    l = 0;
    if (r) m = 0;
    else if (ld) begin
      if (lv[3:0] <= 4'd9 && lv[7:4] <= 4'd9) m = int'(lv[7:4]) * 10 + int'(lv[3:0]);
      else l = 1;
    end else if (e) begin
      if (u && m == 99) begin o = 1; m = w ? 0 : 99; end
      else if (!u && m == 0) begin o = 1; m = w ? 99 : 0; end
      else m = u ? m + 1 : m - 1;
    end
  endtask

  task automatic cyc(input string nm, input bit r, input bit ld, input logic [7:0] lv,
                     input bit e, input bit u);
    exp_t x;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; en = e; up_dn = u;
    mstep(m1, o1, l1, 1'b1, r, ld, lv, e, u);
    mstep(m2, o2, l2, 1'b0, r, ld, lv, e, u);
    x.name = nm;
    x.q1 = to_bcd(m1); x.q2 = to_bcd(m2);
    x.o1 = o1; x.o2 = o2; x.l1 = l1; x.l2 = l2;
    x.t1 = e & (u ? m1 == 99 : m1 == 0);
    x.t2 = e & (u ? m2 == 99 : m2 == 0);
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.name, " Q wrap"}, q1, x.q1);
      chk({x.name, " ovf wrap"}, {7'b0, ovf1}, {7'b0, x.o1});
      chk({x.name, " load_err wrap"}, {7'b0, le1}, {7'b0, x.l1});
      chk({x.name, " tc wrap"}, {7'b0, tc1}, {7'b0, x.t1});
      chk({x.name, " Q sat"}, q2, x.q2);
      chk({x.name, " ovf sat"}, {7'b0, ovf2}, {7'b0, x.o2});
      chk({x.name, " load_err sat"}, {7'b0, le2}, {7'b0, x.l2});
      chk({x.name, " tc sat"}, {7'b0, tc2}, {7'b0, x.t2});
      chk({x.name, " digits bcd"},
          {7'b0, q1[3:0] <= 4'd9 && q1[7:4] <= 4'd9 && q2[3:0] <= 4'd9 && q2[7:4] <= 4'd9}, 8'h01);
    end
  end

  initial begin
    cyc("reset", 1, 0, 8'h00, 0, 1);
    cyc("reset_en_down", 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 100; i++) cyc("up_sweep", 0, 0, 8'h00, 1, 1);
    cyc("idle_after_wrap", 0, 0, 8'h00, 0, 1);
    cyc("load_50", 0, 1, 8'h50, 0, 1);
    cyc("down_borrow", 0, 0, 8'h00, 1, 0);
    cyc("load_3c_bad", 0, 1, 8'h3C, 0, 1);
    cyc("after_bad", 0, 0, 8'h00, 0, 1);
    cyc("load_a5_bad_en", 0, 1, 8'hA5, 1, 1);
    cyc("load_99", 0, 1, 8'h99, 0, 1);
    for (int i = 0; i < 3; i++) cyc("sat_at_99", 0, 0, 8'h00, 1, 1);
    cyc("dir_flip_down", 0, 0, 8'h00, 1, 0);
    cyc("load_42", 0, 1, 8'h42, 0, 1);
    cyc("load_en_07", 0, 1, 8'h07, 1, 1);
    cyc("load_00", 0, 1, 8'h00, 0, 0);
    cyc("down_wrap", 0, 0, 8'h00, 1, 0);
    cyc("down_after", 0, 0, 8'h00, 1, 0);
    cyc("load_en_99_at_tc", 0, 1, 8'h99, 1, 1);
    cyc("load_89", 0, 1, 8'h89, 0, 1);
    cyc("up_89", 0, 0, 8'h00, 1, 1);
    cyc("reset_mid_count", 1, 0, 8'h00, 1, 1);
    cyc("resume_up", 0, 0, 8'h00, 1, 1);
    cyc("hold", 0, 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
